// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the system-bus arbiter: owner encoding, active-low
// enable levels and the round-robin search used to pick the next owner.
package bus_arbiter_pkg;

    localparam int NUM_MASTERS = 4;
    localparam int BUS_OWNER_W = 2;

    typedef logic [BUS_OWNER_W-1:0] bus_owner_t;

    localparam bus_owner_t BUS_OWNER_MASTER_0 = 2'd0;
    localparam bus_owner_t BUS_OWNER_MASTER_1 = 2'd1;
    localparam bus_owner_t BUS_OWNER_MASTER_2 = 2'd2;
    localparam bus_owner_t BUS_OWNER_MASTER_3 = 2'd3;

    // Request and grant lines are active-low on the bus.
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    // Next owner given the current owner and the active-high request vector.
    // The owner keeps the bus while it requests. Once it releases, the search
    // starts at owner+1 and never revisits the owner itself. With nobody else
    // requesting the bus stays parked on the current owner.
    function automatic bus_owner_t rr_next_owner(input bus_owner_t cur,
                                                 input logic [NUM_MASTERS-1:0] req_active);
        bus_owner_t cand;
        bus_owner_t result;
        logic       found;
        result = cur;
        found  = 1'b0;
        cand   = cur;
        if (!req_active[cur]) begin
            for (int i = 1; i < NUM_MASTERS; i++) begin
                cand = cur + bus_owner_t'(i);
                if (!found && req_active[cand]) begin
                    result = cand;
                    found  = 1'b1;
                end
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/bus_arbiter.sv
// Four-master round-robin bus arbiter with active-low requests and grants.
// Ownership is held until the owner releases its request, then rotates; with
// no requests pending the bus stays parked on the last owner.
module bus_arbiter
    import bus_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       m0_req_,
    input  logic       m1_req_,
    input  logic       m2_req_,
    input  logic       m3_req_,
    output logic       m0_grnt_,
    output logic       m1_grnt_,
    output logic       m2_grnt_,
    output logic       m3_grnt_,
    output logic [1:0] owner,
    output logic       arb_switch
);

    logic [NUM_MASTERS-1:0] req_active;
    bus_owner_t             owner_reg;
    bus_owner_t             owner_next;
    logic                   switch_reg;
    logic                   switch_next;
    logic [NUM_MASTERS-1:0] grnt_reg;
    logic [NUM_MASTERS-1:0] grnt_next;

    assign req_active = ~{m3_req_, m2_req_, m1_req_, m0_req_};

    // Rotation search and one-cycle switch pulse on any ownership change.
    always_comb begin
        owner_next  = rr_next_owner(owner_reg, req_active);
        switch_next = (owner_next != owner_reg);
    end

    // Owner and switch-pulse registers; reset parks the bus on master 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_reg  <= BUS_OWNER_MASTER_0;
            switch_reg <= 1'b0;
        end else begin
            owner_reg  <= owner_next;
            switch_reg <= switch_next;
        end
    end

    // Grants are registered copies of the one-hot decode of the next owner,
    // so they always agree with owner and exactly one is asserted.
    generate
        for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_grant
            assign grnt_next[gi] = (owner_next == bus_owner_t'(gi)) ? ENABLE_ : DISABLE_;

            // Per-master grant flop; master 0 holds the bus out of reset.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    grnt_reg[gi] <= (gi == 0) ? ENABLE_ : DISABLE_;
                end else begin
                    grnt_reg[gi] <= grnt_next[gi];
                end
            end
        end
    endgenerate

    assign m0_grnt_   = grnt_reg[0];
    assign m1_grnt_   = grnt_reg[1];
    assign m2_grnt_   = grnt_reg[2];
    assign m3_grnt_   = grnt_reg[3];
    assign owner      = owner_reg;
    assign arb_switch = switch_reg;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios followed by a long
// random run checked against a behavioural round-robin model.
module tb_bus_arbiter;

    logic       clk;
    logic       reset;
    logic       m0_req_, m1_req_, m2_req_, m3_req_;
    logic       m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_;
    logic [1:0] owner;
    logic       arb_switch;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    int m_owner  = 0;
    bit m_switch = 0;

    bus_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .m0_req_    (m0_req_),
        .m1_req_    (m1_req_),
        .m2_req_    (m2_req_),
        .m3_req_    (m3_req_),
        .m0_grnt_   (m0_grnt_),
        .m1_grnt_   (m1_grnt_),
        .m2_grnt_   (m2_grnt_),
        .m3_grnt_   (m3_grnt_),
        .owner      (owner),
        .arb_switch (arb_switch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] grants();
        return {m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_};
    endfunction

    // Drive an active-low request vector {m3,m2,m1,m0}, advance one edge,
    // update the model from the rules, and return 1ns after the edge.
    task automatic drive_cycle(input logic [3:0] rn);
        int  nxt;
        bit  found;
        {m3_req_, m2_req_, m1_req_, m0_req_} = rn;
        @(posedge clk);
        nxt   = m_owner;
        found = 0;
        if (rn[m_owner] == 1'b1) begin
            for (int k = 1; k < 4; k++) begin
                if (!found && rn[(m_owner + k) % 4] == 1'b0) begin
                    nxt   = (m_owner + k) % 4;
                    found = 1;
                end
            end
        end
        m_switch = (nxt != m_owner);
        m_owner  = nxt;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        {m3_req_, m2_req_, m1_req_, m0_req_} = 4'b1111;
        #2 reset = 1'b1;
        #1;
        m_owner = 0; m_switch = 0;
        n_cmp++;
        if (owner !== 2'd0) begin
            n_fail++; $display("FAIL reset_owner: got %0d want 0", owner);
        end
        n_cmp++;
        if (grants() !== 4'b1110) begin
            n_fail++; $display("FAIL reset_grants: got %b want 1110", grants());
        end
        n_cmp++;
        if (arb_switch !== 1'b0) begin
            n_fail++; $display("FAIL reset_switch: got %b want 0", arb_switch);
        end
        $display("test_reset: owner=%0d grants=%b switch=%b", owner, grants(), arb_switch);
        #4 reset = 1'b0;
    endtask

    task automatic test_single_request();
        for (int c = 0; c < 5; c++) begin
            drive_cycle(4'b1011);
            n_cmp++;
            if (owner !== 2'd2 || grants() !== 4'b1011) begin
                n_fail++; $display("FAIL single_grant c%0d: got owner=%0d grants=%b want owner=2 grants=1011", c, owner, grants());
            end
            n_cmp++;
            if (arb_switch !== (c == 0)) begin
                n_fail++; $display("FAIL single_switch c%0d: got %b want %b", c, arb_switch, (c == 0));
            end
        end
        for (int c = 0; c < 2; c++) begin
            drive_cycle(4'b1111);
            n_cmp++;
            if (owner !== 2'd2 || arb_switch !== 1'b0) begin
                n_fail++; $display("FAIL single_park c%0d: got owner=%0d switch=%b want owner=2 switch=0", c, owner, arb_switch);
            end
        end
        $display("test_single_request: owner=%0d grants=%b", owner, grants());
    endtask

    task automatic test_no_preemption();
        drive_cycle(4'b1101);
        n_cmp++;
        if (owner !== 2'd1 || arb_switch !== 1'b1) begin
            n_fail++; $display("FAIL nopre_take: got owner=%0d switch=%b want owner=1 switch=1", owner, arb_switch);
        end
        for (int c = 0; c < 10; c++) begin
            drive_cycle(4'b0100);
            n_cmp++;
            if (owner !== 2'd1 || grants() !== 4'b1101 || arb_switch !== 1'b0) begin
                n_fail++; $display("FAIL nopre_hold c%0d: got owner=%0d grants=%b switch=%b want 1/1101/0", c, owner, grants(), arb_switch);
            end
        end
        drive_cycle(4'b0110);
        n_cmp++;
        if (owner !== 2'd3 || grants() !== 4'b0111 || arb_switch !== 1'b1) begin
            n_fail++; $display("FAIL nopre_release: got owner=%0d grants=%b switch=%b want 3/0111/1", owner, grants(), arb_switch);
        end
        $display("test_no_preemption: owner=%0d", owner);
    endtask

    task automatic test_round_robin();
        int exp_seq [5] = '{0, 1, 2, 3, 0};
        logic [3:0] rn;
        for (int s = 0; s < 5; s++) begin
            rn = 4'b0000;
            rn[owner] = 1'b1;
            drive_cycle(rn);
            n_cmp++;
            if (owner !== 2'(exp_seq[s]) || arb_switch !== 1'b1) begin
                n_fail++; $display("FAIL rr_step%0d: got owner=%0d switch=%b want owner=%0d switch=1", s, owner, arb_switch, exp_seq[s]);
            end
            for (int c = 0; c < 2; c++) begin
                drive_cycle(4'b0000);
                n_cmp++;
                if (owner !== 2'(exp_seq[s]) || arb_switch !== 1'b0) begin
                    n_fail++; $display("FAIL rr_hold%0d: got owner=%0d switch=%b want owner=%0d switch=0", s, owner, arb_switch, exp_seq[s]);
                end
            end
            $display("test_round_robin: step %0d owner=%0d", s, owner);
        end
    endtask

    task automatic test_reset_mid();
        drive_cycle(4'b0111);
        drive_cycle(4'b0111);
        n_cmp++;
        if (owner !== 2'd3) begin
            n_fail++; $display("FAIL midrst_setup: got owner=%0d want 3", owner);
        end
        #2 reset = 1'b1;
        #1;
        m_owner = 0; m_switch = 0;
        n_cmp++;
        if (m0_grnt_ !== 1'b0 || m3_grnt_ !== 1'b1 || owner !== 2'd0 || arb_switch !== 1'b0) begin
            n_fail++; $display("FAIL midrst_async: got m0=%b m3=%b owner=%0d switch=%b want 0/1/0/0", m0_grnt_, m3_grnt_, owner, arb_switch);
        end
        #2 reset = 1'b0;
        drive_cycle(4'b0111);
        n_cmp++;
        if (owner !== 2'd3 || grants() !== 4'b0111 || arb_switch !== 1'b1) begin
            n_fail++; $display("FAIL midrst_regrant: got owner=%0d grants=%b switch=%b want 3/0111/1", owner, grants(), arb_switch);
        end
        $display("test_reset_mid: owner=%0d grants=%b", owner, grants());
    endtask

    task automatic test_random();
        logic [3:0] rn;
        logic [1:0] prev_owner;
        int         wait_cnt [4] = '{0, 0, 0, 0};
        int         changes = 0;
        for (int c = 0; c < 10000; c++) begin
            rn = 4'($urandom);
            prev_owner = owner;
            drive_cycle(rn);
            if (owner != prev_owner) changes++;
            n_cmp++;
            if (owner !== 2'(m_owner) || arb_switch !== m_switch) begin
                n_fail++; $display("FAIL rand_model c%0d: got owner=%0d switch=%b want owner=%0d switch=%b", c, owner, arb_switch, m_owner, m_switch);
            end
            n_cmp++;
            if (!$onehot(~grants()) || grants() !== ~(4'b0001 << m_owner)) begin
                n_fail++; $display("FAIL rand_grant c%0d: got grants=%b want %b", c, grants(), ~(4'b0001 << m_owner));
            end
            n_cmp++;
            if (owner !== prev_owner && rn[prev_owner] !== 1'b1) begin
                n_fail++; $display("FAIL rand_preempt c%0d: owner %0d->%0d while old owner requesting", c, prev_owner, owner);
            end
            for (int m = 0; m < 4; m++) begin
                if (rn[m] == 1'b0 && owner != 2'(m)) begin
                    if (owner != prev_owner) wait_cnt[m]++;
                end else begin
                    wait_cnt[m] = 0;
                end
                n_cmp++;
                if (wait_cnt[m] > 3) begin
                    n_fail++; $display("FAIL rand_starve c%0d m%0d: got %0d changes waited want <=3", c, m, wait_cnt[m]);
                end
            end
        end
        $display("test_random: 10000 cycles, %0d ownership changes", changes);
    endtask

    initial begin
        test_reset();
        test_single_request();
        test_no_preemption();
        test_round_robin();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
